// File: rtl/rv32_regfile_mp.sv
// rv32_regfile_mp: multi-port RV32 integer register file with busy scoreboard.
// Ports: clk/rst (sync, active-high), ready, NRD read ports (raddr/rdata/rbusy),
// NWR write ports (we/waddr/wdata), scoreboard set (sb_set/sb_addr).
module rv32_regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr
);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [XLEN-1:0]   regs_q [NREGS];
  logic [XLEN-1:0]   regs_d [NREGS];
  logic              run;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // next state: walk the clear pointer, leave CLEAR after the last entry
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == CLEAR) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == AW'(NREGS - 1))
        state_d = RUN;
    end
  end

  // outputs of the FSM
  always_comb begin
    run   = (state_q == RUN);
    ready = run;
  end

  // register contents hold while rst is asserted
  always_ff @(posedge clk) begin
    if (!rst)
      regs_q <= regs_d;
  end

  always_comb begin
    regs_d = regs_q;
    if (!run) begin
      regs_d[ptr_q] = '0;
    end else begin
      // ascending loop: highest port index wins
      for (int w = 0; w < NWR; w++) begin
        if (we[w] && waddr[w*AW +: AW] != '0)
          regs_d[waddr[w*AW +: AW]] = wdata[w*XLEN +: XLEN];
      end
    end
  end

  // scoreboard
  always_ff @(posedge clk) begin
    if (rst)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  always_comb begin
    busy_d = busy_q;
    if (run) begin
      for (int w = 0; w < NWR; w++) begin
        if (we[w])
          busy_d[waddr[w*AW +: AW]] = 1'b0;
      end
      // a newly issued producer overrides a retiring one
      if (sb_set && sb_addr != '0)
        busy_d[sb_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // read ports
  logic [AW-1:0]   ra;
  logic            hit;
  logic [XLEN-1:0] byp;

  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    hit   = 1'b0;
    byp   = '0;
    for (int i = 0; i < NRD; i++) begin
      ra  = raddr[i*AW +: AW];
      hit = 1'b0;
      byp = '0;
      if (BYPASS != 0) begin
        for (int w = 0; w < NWR; w++) begin
          if (we[w] && waddr[w*AW +: AW] == ra) begin
            hit = 1'b1;
            byp = wdata[w*XLEN +: XLEN];
          end
        end
      end
      if (run && ra != '0) begin
        rdata[i*XLEN +: XLEN] = hit ? byp : regs_q[ra];
        rbusy[i]              = busy_q[ra] & ~hit;
      end
    end
  end

endmodule

// File: tb/tb_rv32_regfile_mp.sv
// tb_rv32_regfile_mp: directed bench for rv32_regfile_mp.
// Checks default (BYPASS=1), BYPASS=0 and a 16x64, 3R/1W configuration.
module tb_rv32_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  raddr;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic        sb_set;
  logic [4:0]  sb_addr;

  logic        ready, ready_nb;
  logic [63:0] rdata, rdata_nb;
  logic [1:0]  rbusy, rbusy_nb;

  logic         p_ready;
  logic [11:0]  p_raddr;
  logic [191:0] p_rdata;
  logic [2:0]   p_rbusy;
  logic         p_we;
  logic [3:0]   p_waddr;
  logic [63:0]  p_wdata;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  rv32_regfile_mp dut (
    .clk(clk), .rst(rst), .ready(ready),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata),
    .sb_set(sb_set), .sb_addr(sb_addr)
  );

  rv32_regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .ready(ready_nb),
    .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
    .we(we), .waddr(waddr), .wdata(wdata),
    .sb_set(sb_set), .sb_addr(sb_addr)
  );

  rv32_regfile_mp #(
    .XLEN(64), .NREGS(16), .NRD(3), .NWR(1)
  ) dut_p (
    .clk(clk), .rst(rst), .ready(p_ready),
    .raddr(p_raddr), .rdata(p_rdata), .rbusy(p_rbusy),
    .we(p_we), .waddr(p_waddr), .wdata(p_wdata),
    .sb_set(1'b0), .sb_addr(4'd0)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we      = '0;
    waddr   = '0;
    wdata   = '0;
    sb_set  = 1'b0;
    sb_addr = '0;
  endtask

  initial begin
    rst = 1'b1; raddr = '0; idle();
    p_raddr = '0; p_we = 1'b0; p_waddr = '0; p_wdata = '0;
    tick(); tick();
    #1;
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_rbusy", 64'(rbusy), 64'd0);
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 15) check("p_ready15", 64'(p_ready), 64'd0);
      if (k == 16) check("p_ready16", 64'(p_ready), 64'd1);
      if (k == 31) check("ready31", 64'(ready), 64'd0);
      if (k == 32) check("ready32", 64'(ready), 64'd1);
      if (k == 32) check("nb_ready32", 64'(ready_nb), 64'd1);
    end

    // seed x3, reset, expect it cleared
    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'd0, 32'hDEADBEEF};
    tick(); idle();
    raddr = {5'd0, 5'd3}; #1;
    check("seed_x3", rdata[31:0], 64'hDEADBEEF);
    rst = 1'b1; tick(); tick(); #1;
    check("rst2_ready", 64'(ready), 64'd0);
    check("rst2_rdata", rdata, 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 32; k++) tick();
    #1;
    check("rst2_ready_up", 64'(ready), 64'd1);
    check("x3_cleared", rdata[31:0], 64'd0);

    // write/read
    we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'd0, 32'h12345678};
    tick(); idle();
    raddr = {5'd0, 5'd5}; #1;
    check("x5_read", rdata[31:0], 64'h12345678);
    we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'd0, 32'hFFFFFFFF};
    tick(); idle();
    raddr = {5'd0, 5'd0}; #1;
    check("x0_read", rdata[31:0], 64'd0);

    // write conflict and bypass
    we = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'd0, 32'h11111111};
    tick();
    we = 2'b11; waddr = {5'd7, 5'd7};
    wdata = {32'h5555FFFF, 32'hAAAA0000};
    raddr = {5'd7, 5'd0}; #1;
    check("byp_rdata1", rdata[63:32], 64'h5555FFFF);
    check("nb_rdata1", rdata_nb[63:32], 64'h11111111);
    tick(); idle(); #1;
    check("conf_rdata1", rdata[63:32], 64'h5555FFFF);
    check("nb_conf_rdata1", rdata_nb[63:32], 64'h5555FFFF);

    // scoreboard
    sb_set = 1'b1; sb_addr = 5'd9; raddr = {5'd0, 5'd9};
    tick(); idle(); #1;
    check("sb_busy", 64'(rbusy[0]), 64'd1);
    check("nb_sb_busy", 64'(rbusy_nb[0]), 64'd1);
    we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'd0, 32'h00000099};
    sb_set = 1'b1; sb_addr = 5'd9; #1;
    check("sb_byp_sup", 64'(rbusy[0]), 64'd0);
    check("nb_sb_same", 64'(rbusy_nb[0]), 64'd1);
    tick(); idle(); #1;
    check("sb_setwins", 64'(rbusy[0]), 64'd1);
    check("nb_sb_setwins", 64'(rbusy_nb[0]), 64'd1);
    we = 2'b10; waddr = {5'd9, 5'd0}; wdata = {32'h0000009A, 32'd0}; #1;
    check("sb_clr_byp", 64'(rbusy[0]), 64'd0);
    check("nb_sb_clr_same", 64'(rbusy_nb[0]), 64'd1);
    tick(); idle(); #1;
    check("sb_clr", 64'(rbusy[0]), 64'd0);
    check("nb_sb_clr", 64'(rbusy_nb[0]), 64'd0);
    check("x9_read", rdata[31:0], 64'h9A);
    sb_set = 1'b1; sb_addr = 5'd0;
    tick(); idle(); raddr = '0; #1;
    check("sb_x0", 64'(rbusy[0]), 64'd0);

    // reset mid-clear, writes during clear ignored
    rst = 1'b1; tick(); tick();
    rst = 1'b0;
    we = 2'b01; waddr = {5'd0, 5'd12}; wdata = {32'd0, 32'h00000BAD};
    sb_set = 1'b1; sb_addr = 5'd12;
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 22) check("mid_ready22", 64'(ready), 64'd0);
      if (k == 31) check("mid_ready31", 64'(ready), 64'd0);
      if (k == 32) begin
        check("mid_ready32", 64'(ready), 64'd1);
        idle();
      end
    end
    raddr = {5'd0, 5'd12}; #1;
    check("clr_wr_ign", rdata[31:0], 64'd0);
    check("clr_sb_ign", 64'(rbusy[0]), 64'd0);

    // 16x64, 3R/1W configuration
    p_we = 1'b1; p_waddr = 4'd1; p_wdata = 64'h0123456789ABCDEF;
    tick();
    p_waddr = 4'd2; p_wdata = 64'hFEDCBA9876543210;
    tick();
    p_waddr = 4'd15; p_wdata = 64'h8000000000000001;
    tick();
    p_we = 1'b0;
    p_raddr = {4'd1, 4'd2, 4'd15}; #1;
    check("p_rd0", p_rdata[63:0], 64'h8000000000000001);
    check("p_rd1", p_rdata[127:64], 64'hFEDCBA9876543210);
    check("p_rd2", p_rdata[191:128], 64'h0123456789ABCDEF);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
